// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH full-adder slices: {cout, sum} = a + b + cin.
// Latency: 1 cycle when REG_OUT=1, 0 cycles (combinational) when REG_OUT=0.
// No backpressure: accepts a new operand set on every in_valid cycle, never stalls.
module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        assign sum_comb[i]  = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1]   = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    if (REG_OUT) begin : g_reg
        // Result registers only load on in_valid, so idle-cycle garbage never reaches them.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum       <= '0;
                cout      <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    sum  <= sum_comb;
                    cout <= carry[WIDTH];
                end
            end
        end
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign sum            = sum_comb;
        assign cout           = carry[WIDTH];
        assign out_valid      = in_valid;
    end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: registered instances at WIDTH 1/4/8/64 checked by a queue scoreboard,
// plus two combinational WIDTH=1 instances chained into a 2-bit adder.
module tb_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       v1, ci1, co1, ov1;
    logic [0:0] a1, b1, s1;
    logic       v4, ci4, co4, ov4;
    logic [3:0] a4, b4, s4;
    logic       v8, ci8, co8, ov8;
    logic [7:0] a8, b8, s8;
    logic        v64, ci64, co64, ov64;
    logic [63:0] a64, b64, s64;

    logic       cv, cc0, ca, cb, cc, cd;
    logic [0:0] csum1, csum2;
    logic       ck, cout2, cov_a, cov_b;

    full_adder #(.WIDTH(1),  .REG_OUT(1'b1)) u_w1  (.clk(clk), .rst(rst), .in_valid(v1),  .cin(ci1),  .a(a1),  .b(b1),  .sum(s1),  .cout(co1),  .out_valid(ov1));
    full_adder #(.WIDTH(4),  .REG_OUT(1'b1)) u_w4  (.clk(clk), .rst(rst), .in_valid(v4),  .cin(ci4),  .a(a4),  .b(b4),  .sum(s4),  .cout(co4),  .out_valid(ov4));
    full_adder #(.WIDTH(8),  .REG_OUT(1'b1)) u_w8  (.clk(clk), .rst(rst), .in_valid(v8),  .cin(ci8),  .a(a8),  .b(b8),  .sum(s8),  .cout(co8),  .out_valid(ov8));
    full_adder #(.WIDTH(64), .REG_OUT(1'b1)) u_w64 (.clk(clk), .rst(rst), .in_valid(v64), .cin(ci64), .a(a64), .b(b64), .sum(s64), .cout(co64), .out_valid(ov64));

    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_ch0 (.clk(clk), .rst(rst), .in_valid(cv), .cin(cc0), .a(ca), .b(cb), .sum(csum1), .cout(ck),    .out_valid(cov_a));
    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_ch1 (.clk(clk), .rst(rst), .in_valid(cv), .cin(ck),  .a(cc), .b(cd), .sum(csum2), .cout(cout2), .out_valid(cov_b));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Scoreboard: one queue of expected {cout,sum} values per registered instance.
    logic [64:0] expq [4][$];
    logic [64:0] held [4];
    logic [64:0] got  [4];
    logic        ovv  [4];
    string       names[4] = '{"w1", "w4", "w8", "w64"};

    always_comb begin
        got[0] = 65'({co1, s1});
        got[1] = 65'({co4, s4});
        got[2] = 65'({co8, s8});
        got[3] = {co64, s64};
        ovv[0] = ov1;
        ovv[1] = ov4;
        ovv[2] = ov8;
        ovv[3] = ov64;
    end

    task automatic push_all();
        if (!rst) begin
            if (v1)  expq[0].push_back(65'(a1)  + 65'(b1)  + 65'(ci1));
            if (v4)  expq[1].push_back(65'(a4)  + 65'(b4)  + 65'(ci4));
            if (v8)  expq[2].push_back(65'(a8)  + 65'(b8)  + 65'(ci8));
            if (v64) expq[3].push_back(65'(a64) + 65'(b64) + 65'(ci64));
        end
    endtask

    logic rst_seen = 1'b0;
    logic mon_en   = 1'b0;
    always @(posedge clk) begin
        rst_seen <= rst;
        mon_en   <= mon_en | rst;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                if (rst_seen) begin
                    chk($sformatf("%s_reset", names[i]), {ovv[i], got[i][63:0]} | 65'(got[i][64]), 65'd0);
                    held[i] = '0;
                end else if (ovv[i]) begin
                    if (expq[i].size() == 0) begin
                        chk($sformatf("%s_spurious_valid", names[i]), 65'(ovv[i]), 65'd0);
                    end else begin
                        held[i] = expq[i].pop_front();
                        chk($sformatf("%s_result", names[i]), got[i], held[i]);
                    end
                end else begin
                    chk($sformatf("%s_hold", names[i]), got[i], held[i]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        v1 = 1'b0; v4 = 1'b0; v8 = 1'b0; v64 = 1'b0;
    endtask

    task automatic set4(input logic [3:0] x, input logic [3:0] y, input logic c, input logic v);
        a4 = x; b4 = y; ci4 = c; v4 = v;
    endtask

    task automatic chain_check(input logic [4:0] vec);
        logic [2:0] exp;
        {cc0, ca, cb, cc, cd} = vec;
        cv = vec[0] ^ vec[4];
        #1;
        // The two slices form a 2-bit adder: {c,a} + {d,b} + cin.
        exp = 3'({cc, ca}) + 3'({cd, cb}) + 3'(cc0);
        chk("chain_sum", 65'({cout2, csum2, csum1}), 65'(exp));
        chk("chain_valid", 65'({cov_a, cov_b}), 65'({cv, cv}));
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        {ci1, a1, b1} = '0; set4(4'h0, 4'h0, 1'b0, 1'b0);
        ci8 = 1'b0; a8 = '0; b8 = '0; ci64 = 1'b0; a64 = '0; b64 = '0;
        {cv, cc0, ca, cb, cc, cd} = '0;
        step(); step();
        rst = 1'b0;
        step();

        // Single full adder: every {a,b,cin} combination back to back.
        for (int k = 0; k < 8; k++) begin
            {a1, b1, ci1} = 3'(k);
            v1 = 1'b1;
            push_all();
            step();
        end
        v1 = 1'b0;
        step();

        // WIDTH=4 directed vectors, ending on 3+4 so the hold test sees 4'h7.
        set4(4'hF, 4'h1, 1'b0, 1'b1); push_all(); step();
        set4(4'h7, 4'h8, 1'b1, 1'b1); push_all(); step();
        set4(4'h3, 4'h4, 1'b0, 1'b1); push_all(); step();
        for (int k = 0; k < 3; k++) begin
            set4(4'(k * 5 + 9), 4'(k * 3 + 6), 1'(k), 1'b0);
            step();
        end
        chk("w4_hold_value", 65'({co4, s4}), 65'h7);

        // Reset wins over a simultaneous valid.
        rst = 1'b1;
        set4(4'hF, 4'hF, 1'b1, 1'b1); push_all(); step();
        rst = 1'b0;
        set4(4'h0, 4'h0, 1'b0, 1'b0); step();
        chk("w4_after_reset", 65'({ov4, co4, s4}), 65'd0);
        set4(4'h9, 4'h9, 1'b1, 1'b1); push_all(); step();
        v4 = 1'b0;
        step();

        // Combinational chain, including with rst asserted to show it is ignored.
        chain_check(5'b1_0_1_1_1);
        for (int k = 0; k < 12; k++) begin
            rst = 1'(k % 3 == 0);
            chain_check(5'($urandom_range(0, 31)));
        end
        rst = 1'b0;
        step();

        // Random traffic on all registered instances, with occasional mid-stream reset.
        for (int k = 0; k < 1000; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            v1  = 1'($urandom);  ci1  = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
            v4  = 1'($urandom);  ci4  = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
            v8  = 1'($urandom);  ci8  = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            v64 = 1'($urandom);  ci64 = 1'($urandom);
            a64 = {$urandom, $urandom};
            b64 = {$urandom, $urandom};
            if (k % 50 == 0) begin
                a64 = '1;
                b64 = 64'(k % 2);
            end
            push_all();
            step();
        end
        rst = 1'b0;
        idle_all();
        step(); step(); step();

        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_drain", names[i]), 65'(expq[i].size()), 65'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
